uar_rx: RTL

- UART receiver; the downstream stage that consumes the serial line driven by the UART transmitter (8N1, LSB first, idle high).
- Oversamples ser_in with the system clock, validates the start bit at mid-bit, shifts in 8 data bits and checks the stop bit.
- Presents each received byte on a valid/read handshake to the board-side logic (loopback checker, LED/display).

---
 rtl/uar_rx.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/uar_rx.sv
// uar_rx -- 8N1 UART receiver (LSB first, idle-high line).
//
// Oversamples the serial line with the system clock, qualifies the start
// bit at mid-bit, shifts in 8 data bits and checks the stop bit. Received
// bytes are offered on a valid/read handshake.
//
// Optional feature macro: UAR_RX_PARITY_EN
//   When defined, an even-parity bit follows the data bits and the
//   o_parity_err output is added. A byte failing parity is never loaded.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per serial bit (even, >= 4)
//   CNT_W         sample counter width (2**CNT_W > CLKS_PER_BIT)
//
// Ports:
//   i_clk         system clock, rising edge
//   i_rst_n       asynchronous active-low reset
//   i_ser_in      asynchronous serial input, idle 1
//   i_rd_en       read strobe, acknowledges o_data_out
//   o_data_out    last accepted byte
//   o_data_valid  o_data_out holds an unread byte
//   o_frame_err   one-cycle pulse: stop bit sampled 0
//   o_overrun     sticky: good frame arrived while o_data_valid=1
//   o_rx_busy     high in every state except IDLE
//   o_parity_err  (UAR_RX_PARITY_EN only) one-cycle pulse on parity failure
module uar_rx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int CNT_W        = 5
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_ser_in,
   input  logic       i_rd_en,
   output logic [7:0] o_data_out,
   output logic       o_data_valid,
   output logic       o_frame_err,
   output logic       o_overrun,
`ifdef UAR_RX_PARITY_EN
   output logic       o_rx_busy,
   output logic       o_parity_err
`else
   output logic       o_rx_busy
`endif
);

   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t           r_state;
   logic             r_sync1;
   logic             r_sync2;     // synchronized line (rx_s)
   logic             r_rx_prev;   // rx_s one cycle ago, for edge detect
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_bit_cnt;
   logic [7:0]       r_shift;
   logic [7:0]       r_data_out;
   logic             r_data_valid;
   logic             r_frame_err;
   logic             r_overrun;
   logic             r_busy;
`ifdef UAR_RX_PARITY_EN
   logic             r_par;       // running XOR of data bits
   logic             r_par_bad;
   logic             r_parity_err;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= S_IDLE;
         r_sync1      <= 1'b1;
         r_sync2      <= 1'b1;
         r_rx_prev    <= 1'b1;
         r_cnt        <= '0;
         r_bit_cnt    <= 3'd0;
         r_shift      <= 8'h00;
         r_data_out   <= 8'h00;
         r_data_valid <= 1'b0;
         r_frame_err  <= 1'b0;
         r_overrun    <= 1'b0;
         r_busy       <= 1'b0;
`ifdef UAR_RX_PARITY_EN
         r_par        <= 1'b0;
         r_par_bad    <= 1'b0;
         r_parity_err <= 1'b0;
`endif
      end else begin
         r_sync1     <= i_ser_in;
         r_sync2     <= r_sync1;
         r_rx_prev   <= r_sync2;
         r_frame_err <= 1'b0;
`ifdef UAR_RX_PARITY_EN
         r_parity_err <= 1'b0;
`endif
         // A read acknowledges the byte; a frame completing in the same
         // cycle overrides data_valid below so it stays set.
         if (i_rd_en && r_data_valid) begin
            r_data_valid <= 1'b0;
            r_overrun    <= 1'b0;
         end

         case (r_state)
            S_IDLE: begin
               // Only a true 1->0 edge starts a frame, so a held break
               // line cannot retrigger.
               if (r_rx_prev && !r_sync2) begin
                  r_state <= S_START;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
               end
            end
            S_START: begin
               if (r_cnt == HALF_M1) begin
                  r_cnt <= '0;
                  if (!r_sync2) begin
                     r_state   <= S_DATA;
                     r_bit_cnt <= 3'd0;
`ifdef UAR_RX_PARITY_EN
                     r_par     <= 1'b0;
`endif
                  end else begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DATA: begin
               if (r_cnt == FULL_M1) begin
                  r_cnt     <= '0;
                  r_shift   <= {r_sync2, r_shift[7:1]};
                  r_bit_cnt <= r_bit_cnt + 3'd1;
`ifdef UAR_RX_PARITY_EN
                  r_par     <= r_par ^ r_sync2;
                  if (r_bit_cnt == 3'd7)
                     r_state <= S_PARITY;
`else
                  if (r_bit_cnt == 3'd7)
                     r_state <= S_STOP;
`endif
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
`ifdef UAR_RX_PARITY_EN
            S_PARITY: begin
               if (r_cnt == FULL_M1) begin
                  r_cnt     <= '0;
                  r_par_bad <= r_par ^ r_sync2;
                  r_state   <= S_STOP;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
`endif
            S_STOP: begin
               if (r_cnt == FULL_M1) begin
                  r_cnt   <= '0;
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
`ifdef UAR_RX_PARITY_EN
                  if (r_par_bad)
                     r_parity_err <= 1'b1;
                  if (!r_sync2) begin
                     r_frame_err <= 1'b1;
                  end else if (!r_par_bad) begin
`else
                  if (!r_sync2) begin
                     r_frame_err <= 1'b1;
                  end else begin
`endif
                     if (!r_data_valid || i_rd_en) begin
                        r_data_out   <= r_shift;
                        r_data_valid <= 1'b1;
                     end else begin
                        r_overrun <= 1'b1;
                     end
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign o_data_out   = r_data_out;
   assign o_data_valid = r_data_valid;
   assign o_frame_err  = r_frame_err;
   assign o_overrun    = r_overrun;
   assign o_rx_busy    = r_busy;
`ifdef UAR_RX_PARITY_EN
   assign o_parity_err = r_parity_err;
`endif

endmodule
